dmem_responder: RTL

Data-memory responder serving load/store requests from the pipeline's memory stage over a valid/ready request channel and a valid/ready response channel. It has a configurable access latency and RV32I byte, half and word semantics selected by func3. It is the responder end of the processor's data-memory interface and replaces the single-cycle data memory when stall-capable timing is needed.

---
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder with a valid/ready request/response handshake, programmable access latency and RV32I sizes.
// Optional build macro DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into errors instead of forcing alignment.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W+1:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         func3_q, func3_d;
    logic               err_q, err_d;

    logic               access;
    logic               acc_err;
    logic               legal;
    logic               misalign;
    logic [3:0]         be;
    logic [31:0]        lane_wdata;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        rd_word;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_ext;
    logic               unused_addr_hi;

    // Address bits above the array are deliberately ignored so accesses wrap.
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];
    assign idx            = addr_q[IDX_W+1:2];
    assign access         = rst && (state_q == WAIT) && (cnt_q == 4'd0);
    assign req_ready      = rst && (state_q == IDLE);
    assign rsp_valid      = (state_q == RESP);
    assign rsp_err        = (state_q == RESP) && err_q;

    // Access legality, byte enables and lane-replicated store data.
    always_comb begin
        legal      = 1'b0;
        misalign   = 1'b0;
        be         = 4'b0000;
        lane_wdata = wdata_q;
        if (we_q) begin
            legal = (func3_q == 3'b000) || (func3_q == 3'b001) || (func3_q == 3'b010);
        end else begin
            legal = (func3_q == 3'b000) || (func3_q == 3'b001) || (func3_q == 3'b010) ||
                    (func3_q == 3'b100) || (func3_q == 3'b101);
        end
`ifdef DMEM_MISALIGN_ERR_EN
        case (func3_q[1:0])
            2'b01:   misalign = addr_q[0];
            2'b10:   misalign = (addr_q[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
`endif
        case (func3_q[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be         = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be         = 4'b1111;
                lane_wdata = wdata_q;
            end
            default: begin
                be         = 4'b0000;
                lane_wdata = wdata_q;
            end
        endcase
        acc_err = !legal || misalign;
    end

    // One byte-wide RAM per lane gives per-byte write enables with a registered read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rd_q;

            always_ff @(posedge clk) begin
                if (access && we_q && !acc_err && be[gi]) begin
                    lane_mem[idx] <= lane_wdata[8*gi +: 8];
                end
                if (access && !we_q) begin
                    lane_rd_q <= lane_mem[idx];
                end
            end

            assign rd_word[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

    // Load extraction and extension; the selecting fields stay latched through RESP.
    always_comb begin
        byte_sel = rd_word[7:0];
        case (addr_q[1:0])
            2'b00: byte_sel = rd_word[7:0];
            2'b01: byte_sel = rd_word[15:8];
            2'b10: byte_sel = rd_word[23:16];
            2'b11: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (func3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            3'b010:  load_ext = rd_word;
            default: load_ext = 32'd0;
        endcase
        rsp_rdata = 32'd0;
        if ((state_q == RESP) && !we_q && !err_q) begin
            rsp_rdata = load_ext;
        end
    end

    // Next-state logic; the counter runs LATENCY..0 so RESP begins LATENCY+1 edges after acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        func3_d = func3_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr[IDX_W+1:0];
                    wdata_d = req_wdata;
                    func3_d = req_func3;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    err_d   = acc_err;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            func3_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            err_q   <= err_d;
        end
    end

endmodule
